edu_esm_frontend: RTL

- Parametrised successor to the per-cell ESM (error syndrome measurement) front end inside the EDU cell array.
- Buffers ancilla measurements in a FIFO of depth BUF_DEPTH, replacing the old fixed 2-entry buffer.
- Produces detection events from measurement differences and keeps an ESM_DEPTH-deep history register with head/first/second-index clears.
- Adds occupancy, overflow and set-bit-index outputs used by the cell decoder and spike generator.

---
 rtl/edu_esm_frontend.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/edu_esm_frontend.sv
// EDU cell ESM front end: measurement FIFO, detection events, ESM history.
// Optional macro EDU_BUF_BYPASS_EN feeds aqmeas straight to an empty head.
module edu_esm_frontend #(
  parameter int BUF_DEPTH = 4,
  parameter int ESM_DEPTH = 4,
  parameter int IDX_BW    = $clog2(ESM_DEPTH),
  parameter int CNT_BW    = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 active,
  input  logic                 aqmeas_valid,
  input  logic                 aqmeas,
  input  logic                 pop_aqmeasbuf,
  input  logic                 set_first_aqmeas,
  input  logic                 wr_zeroesm,
  input  logic                 last_aqmeas_flip,
  input  logic                 apply_aqmeas_flip,
  input  logic                 set_measerr_flag,
  input  logic                 clr_head,
  input  logic                 clr_first,
  input  logic                 clr_second,
  output logic                 buf_valid,
  output logic [CNT_BW-1:0]    buf_count,
  output logic                 buf_ovf,
  output logic                 esm_head,
  output logic                 esm_exist,
  output logic [ESM_DEPTH-1:0] esm_vec,
  output logic [IDX_BW-1:0]    first_idx,
  output logic                 first_found,
  output logic [IDX_BW-1:0]    second_idx,
  output logic                 second_found,
  output logic                 eigen
);
  localparam int PW = $clog2(BUF_DEPTH);

  logic                 mem_q [BUF_DEPTH];
  logic [PW-1:0]        rd_q, wr_q;
  logic [CNT_BW-1:0]    cnt_q;
  logic                 ovf_q;
  logic                 first_q, first_d;
  logic                 prev0_q, prev0_d;
  logic                 prev1_q, prev1_d;
  logic                 flip_q, flip_d;
  logic                 merr_q, merr_d;
  logic [ESM_DEPTH-1:0] esm_q, esm_d;

  logic bypass, head, pop, fifo_pop;
  logic full, push_ok, drop, esm_val;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef EDU_BUF_BYPASS_EN
  assign bypass = (cnt_q == '0) & aqmeas_valid & pop_aqmeasbuf;
`else
  assign bypass = 1'b0;
`endif

  assign head      = bypass ? aqmeas : mem_q[rd_q];
  assign buf_valid = (cnt_q != '0) | bypass;
  assign pop       = pop_aqmeasbuf & buf_valid;
  assign fifo_pop  = pop & ~bypass;
  assign full      = (cnt_q == CNT_BW'(BUF_DEPTH));
  assign push_ok   = aqmeas_valid & ~bypass & (~full | fifo_pop);
  assign drop      = aqmeas_valid & ~bypass & full & ~fifo_pop;

  assign esm_val = (first_q | wr_zeroesm | ~active) ? 1'b0
                 : head ^ prev0_q ^ merr_q;

  always_comb begin
    first_idx    = '0;
    second_idx   = '0;
    first_found  = 1'b0;
    second_found = 1'b0;
    for (int i = 0; i < ESM_DEPTH; i++) begin
      if (esm_q[i]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = IDX_BW'(i);
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = IDX_BW'(i);
        end
      end
    end
  end

  always_comb begin
    prev0_d = prev0_q;
    prev1_d = prev1_q;
    first_d = first_q;
    merr_d  = merr_q;
    flip_d  = flip_q;
    esm_d   = esm_q;
    if (pop) begin
      prev0_d = first_q ? 1'b0 : prev1_q;
      prev1_d = head;
      first_d = 1'b0;
      merr_d  = 1'b0;
    end else begin
      if (set_first_aqmeas) first_d = 1'b1;
      if (set_measerr_flag & esm_q[0]) merr_d = 1'b1;
    end
    // Flip acts on whatever prev0 is about to become, including a fresh load.
    if (apply_aqmeas_flip & flip_q) prev0_d = ~prev0_d;
    if (last_aqmeas_flip) flip_d = 1'b1;
    else if (apply_aqmeas_flip) flip_d = 1'b0;
    if (pop | wr_zeroesm)
      esm_d = {esm_val, esm_q[ESM_DEPTH-1:1]};
    else if (clr_head)
      esm_d[0] = 1'b0;
    else if (clr_first & first_found)
      esm_d[first_idx] = 1'b0;
    else if (clr_second & second_found) begin
      esm_d[0]          = 1'b0;
      esm_d[second_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= aqmeas;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
      prev0_q <= 1'b0;
      prev1_q <= 1'b0;
      flip_q  <= 1'b0;
      merr_q  <= 1'b0;
      esm_q   <= '0;
    end else begin
      if (push_ok)  wr_q <= nxt(wr_q);
      if (fifo_pop) rd_q <= nxt(rd_q);
      cnt_q   <= cnt_q + CNT_BW'(push_ok) - CNT_BW'(fifo_pop);
      if (drop) ovf_q <= 1'b1;
      first_q <= first_d;
      prev0_q <= prev0_d;
      prev1_q <= prev1_d;
      flip_q  <= flip_d;
      merr_q  <= merr_d;
      esm_q   <= esm_d;
    end
  end

  assign buf_count = cnt_q;
  assign buf_ovf   = ovf_q;
  assign esm_head  = esm_q[0];
  assign esm_exist = |esm_q;
  assign esm_vec   = esm_q;
  assign eigen     = merr_q ^ prev1_q ^ prev0_q;
endmodule
